i_mem_loader: RTL and testbench

I_MEM_LOADER -- requirements
Module: i_mem_loader

---
 rtl/i_mem_loader.sv | 208 ++++++++++++++++++++
 tb/tb_i_mem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i_mem_loader.sv
// ---------------------------------------------------------------------------
// i_mem_loader
//
// Loads a program into an instruction memory from a byte stream while
// holding the CPU core stalled.
//
// Stream format: N (16-bit word count, little-endian: low byte then high byte),
// then N * 4 instruction bytes. Each word is little-endian and is written to
// word address 0, 1, ... N-1. With I_MEM_LOADER_CSUM_EN defined, one trailing
// byte follows. It must equal the modulo-256 sum of all data bytes.
//
// Optional feature macro: I_MEM_LOADER_CSUM_EN
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous active-high reset
//   start        : single-cycle request to begin a load (IDLE/DONE/ERR only)
//   in_valid     : byte-stream valid
//   in_data      : byte-stream data
//   in_ready     : loader can accept a byte (LEN0/LEN1/DATA/CSUM)
//   writeEnable  : one-cycle instruction memory write strobe
//   writeAddress : instruction memory word address
//   writeData    : instruction word
//   cpu_hold     : stalls the core while a load is in progress
//   done         : load completed; held until the next start
//   error        : load aborted; held until the next start
// ---------------------------------------------------------------------------
module i_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    // Largest legal word count: the whole write-port address space.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    // State reached once the last data word (or an empty image) is taken.
`ifdef I_MEM_LOADER_CSUM_EN
    localparam logic [2:0] S_AFTER_DATA = S_CSUM;
`else
    localparam logic [2:0] S_AFTER_DATA = S_DONE;
`endif

    logic [2:0]            state_q,    state_d;
    logic [7:0]            len_lo_q,   len_lo_d;
    logic [15:0]           len_q,      len_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_buf_q, word_buf_d;
    logic                  we_q,       we_d;
    logic [ADDR_WIDTH-1:0] waddr_q,    waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
`ifdef I_MEM_LOADER_CSUM_EN
    logic [7:0]            sum_q,      sum_d;
`endif

    logic                  accept;
    logic [15:0]           len_full;
    logic [DATA_WIDTH-1:0] assembled;

    // Handshake and status are pure decodes of the state register, so an
    // asynchronous reset clears them in the same cycle.
    always_comb begin
        in_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                   (state_q == S_DATA) || (state_q == S_CSUM);
        cpu_hold = in_ready;
        done     = (state_q == S_DONE);
        error    = (state_q == S_ERR);
    end

    assign accept       = in_valid && in_ready;
    assign len_full     = {in_data, len_lo_q};
    assign writeEnable  = we_q;
    assign writeAddress = waddr_q;
    assign writeData    = wdata_q;

    always_comb begin
        assembled = word_buf_q;
        assembled[{byte_idx_q, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef I_MEM_LOADER_CSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    word_cnt_d = '0;
                    byte_idx_d = '0;
                    word_buf_d = '0;
`ifdef I_MEM_LOADER_CSUM_EN
                    sum_d      = '0;
`endif
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d = len_full;
                    if ({17'd0, len_full} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_AFTER_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_buf_d = assembled;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef I_MEM_LOADER_CSUM_EN
                    sum_d      = sum_q + in_data;
`endif
                    // Fourth byte completes the word: strobe it out next cycle.
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = assembled;
                        waddr_d    = ADDR_WIDTH'(word_cnt_q);
                        word_cnt_d = word_cnt_q + 16'd1;
                        word_buf_d = '0;
                        if ((word_cnt_q + 16'd1) == len_q) begin
                            state_d = S_AFTER_DATA;
                        end
                    end
                end
            end
            S_CSUM: begin
`ifdef I_MEM_LOADER_CSUM_EN
                if (accept) begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
`else
                state_d = S_ERR;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef I_MEM_LOADER_CSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef I_MEM_LOADER_CSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_i_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_i_mem_loader
//
// Directed bench for i_mem_loader. Drives a byte stream with optional idle
// gaps between bytes, logs every write strobe on the falling edge, and
// compares against hand-computed expectations.
// Honours I_MEM_LOADER_CSUM_EN: when it is defined, a checksum byte is appended.
// ---------------------------------------------------------------------------
module tb_i_mem_loader;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          writeEnable;
    logic [AW-1:0] writeAddress;
    logic [DW-1:0] writeData;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int            dbl_pulse = 0;
    logic          prev_we = 1'b0;
    logic [7:0]    stream[$];

    i_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .writeEnable  (writeEnable),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error)
    );

    always #5 clock = ~clock;

    // Write-port monitor: logs strobes and flags strobes longer than a cycle.
    always @(negedge clock) begin
        if (writeEnable) begin
            log_addr.push_back(writeAddress);
            log_data.push_back(writeData);
            if (prev_we) dbl_pulse = dbl_pulse + 1;
        end
        prev_we = writeEnable;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) send_byte(stream[i], gap);
    endtask

    task automatic set_basic_stream();
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef I_MEM_LOADER_CSUM_EN
        stream.push_back(8'hB6);
`endif
    endtask

    task automatic check_basic_result(input string pfx, input int base);
        repeat (3) @(negedge clock);
        check({pfx, "_nwr"},   64'(log_addr.size() - base), 64'd2);
        if (log_addr.size() >= base + 2) begin
            check({pfx, "_a0"}, 64'(log_addr[base]),     64'd0);
            check({pfx, "_d0"}, 64'(log_data[base]),     64'h0000_0013);
            check({pfx, "_a1"}, 64'(log_addr[base + 1]), 64'd1);
            check({pfx, "_d1"}, 64'(log_data[base + 1]), 64'h0010_0093);
        end
        check({pfx, "_done"},  64'(done),     64'd1);
        check({pfx, "_error"}, 64'(error),    64'd0);
        check({pfx, "_hold"},  64'(cpu_hold), 64'd0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_we"},    64'(writeEnable),  64'd0);
        check({pfx, "_waddr"}, 64'(writeAddress), 64'd0);
        check({pfx, "_wdata"}, 64'(writeData),    64'd0);
        check({pfx, "_hold"},  64'(cpu_hold),     64'd0);
        check({pfx, "_done"},  64'(done),         64'd0);
        check({pfx, "_error"}, 64'(error),        64'd0);
        check({pfx, "_rdy"},   64'(in_ready),     64'd0);
    endtask

    initial begin
        int base;

        // Reset state
        repeat (2) @(negedge clock);
        check_outputs_zero("rst");
        reset = 1'b0;
        @(negedge clock);

        // Basic two-word load
        set_basic_stream();
        base = log_addr.size();
        pulse_start();
        check("basic_hold_after_start", 64'(cpu_hold), 64'd1);
        check("basic_rdy_after_start",  64'(in_ready), 64'd1);
        send_range(0, stream.size() - 1, 0);
        check_basic_result("basic", base);

        // Same stream, 3 idle cycles before every byte
        base = log_addr.size();
        pulse_start();
        check("stall_done_cleared", 64'(done), 64'd0);
        send_range(0, stream.size() - 1, 3);
        check_basic_result("stall", base);

        // Oversized length: N = 4097
        base = log_addr.size();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        repeat (3) @(negedge clock);
        check("len_err_error", 64'(error),    64'd1);
        check("len_err_done",  64'(done),     64'd0);
        check("len_err_hold",  64'(cpu_hold), 64'd0);
        check("len_err_nwr",   64'(log_addr.size() - base), 64'd0);

        // Maximum length N = 4096 is accepted (only the start is exercised)
        pulse_start();
        check("len_max_err_cleared", 64'(error), 64'd0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        check("len_max_in_data", 64'(cpu_hold && !error), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Empty image: N = 0
        base = log_addr.size();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef I_MEM_LOADER_CSUM_EN
        send_byte(8'h00, 0);
`endif
        repeat (2) @(negedge clock);
        check("empty_done", 64'(done), 64'd1);
        check("empty_nwr",  64'(log_addr.size() - base), 64'd0);

`ifdef I_MEM_LOADER_CSUM_EN
        // Bad checksum
        stream[stream.size() - 1] = 8'hB7;
        pulse_start();
        send_range(0, stream.size() - 1, 0);
        repeat (3) @(negedge clock);
        check("csum_bad_error", 64'(error), 64'd1);
        check("csum_bad_done",  64'(done),  64'd0);
        set_basic_stream();
`endif

        // Reset after the 5th byte
        base = log_addr.size();
        pulse_start();
        send_range(0, 4, 0);
        #2 reset = 1'b1;
        #1 check_outputs_zero("midrst");
        @(negedge clock);
        reset = 1'b0;
        for (int i = 5; i < stream.size(); i++) begin
            in_valid = 1'b1;
            in_data  = stream[i];
            @(negedge clock);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("midrst_nwr",  64'(log_addr.size() - base), 64'd0);
        check("midrst_idle", 64'({cpu_hold, done, error}), 64'd0);
        base = log_addr.size();
        pulse_start();
        send_range(0, stream.size() - 1, 0);
        check_basic_result("after_rst", base);

        // Start pulsed during DATA is ignored
        base = log_addr.size();
        pulse_start();
        send_range(0, 3, 0);
        pulse_start();
        send_range(4, stream.size() - 1, 0);
        check_basic_result("start_in_data", base);

        check("we_single_cycle", 64'(dbl_pulse), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
